// File: rtl/bus_mem_responder.sv
// Memory-side responder for the tagged 64-bit system bus.
// Serves 8-beat line reads/writes from an on-chip word array.
module bus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int BEATS          = 8,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack,
  output logic                      busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(BEATS);
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, WR_BURST, RD_WAIT, RD_BURST
  } state_t;

  state_t state, state_d;

  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [AW-1:0]            base_q;
  logic [AW-1:0]            base_in;
  logic [BUS_TAG_WIDTH-1:0] tag_q;
  logic [CW-1:0]            cnt, cnt_d;
  logic [LW-1:0]            lat, lat_d;
  logic                     reqack_d;
  logic                     respcyc_d;
  logic                     hdr_take;
  logic                     wr_en;
  logic                     rd_load;
  logic [AW-1:0]            rd_idx;
  logic [AW-1:0]            wr_idx;
  logic                     unused_req;

  // Byte address -> line-aligned word index, wrapping modulo MEM_WORDS
  assign base_in    = bus_req[AW+2:3] & ~AW'(BEATS - 1);
  assign wr_idx     = base_q + AW'(cnt);
  assign unused_req = ^{bus_req[BUS_DATA_WIDTH-1:AW+3], bus_req[2:0]};

  always_comb begin
    state_d   = state;
    reqack_d  = bus_reqack;
    respcyc_d = bus_respcyc;
    cnt_d     = cnt;
    lat_d     = lat;
    hdr_take  = 1'b0;
    wr_en     = 1'b0;
    rd_load   = 1'b0;
    rd_idx    = base_q;
    unique case (state)
      IDLE: begin
        if (bus_reqcyc) begin
          state_d  = HDR;
          reqack_d = 1'b1;
          hdr_take = 1'b1;
        end
      end
      HDR: begin
        cnt_d = '0;
        if (tag_q[BUS_TAG_WIDTH-1]) begin
          state_d = WR_BURST;
        end else begin
          state_d  = RD_WAIT;
          reqack_d = 1'b0;
          lat_d    = LW'(READ_LATENCY - 1);
        end
      end
      WR_BURST: begin
        if (bus_reqcyc) begin
          wr_en = 1'b1;
          if (cnt == LAST) begin
            state_d  = IDLE;
            reqack_d = 1'b0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      RD_WAIT: begin
        if (lat == '0) begin
          state_d   = RD_BURST;
          respcyc_d = 1'b1;
          rd_load   = 1'b1;
        end else begin
          lat_d = lat - LW'(1);
        end
      end
      RD_BURST: begin
        if (bus_respack) begin
          if (cnt == LAST) begin
            state_d   = IDLE;
            respcyc_d = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d   = cnt + CW'(1);
            rd_load = 1'b1;
            rd_idx  = base_q + AW'(cnt) + AW'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        reqack_d  = 1'b0;
        respcyc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
      busy        <= 1'b0;
      cnt         <= '0;
      lat         <= '0;
      base_q      <= '0;
      tag_q       <= '0;
    end else begin
      state       <= state_d;
      bus_reqack  <= reqack_d;
      bus_respcyc <= respcyc_d;
      busy        <= (state_d != IDLE);
      cnt         <= cnt_d;
      lat         <= lat_d;
      if (hdr_take) begin
        base_q <= base_in;
        tag_q  <= bus_reqtag;
      end
      if (rd_load) begin
        bus_resp    <= mem[rd_idx];
        bus_resptag <= tag_q;
      end
    end
  end

  // Store is intentionally not reset; beats written before a reset persist
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_idx] <= bus_req;
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: vector table of line writes/reads,
// read beats checked against a queue of expected beats.
module tb_bus_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] d;
    logic [12:0] t;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [12:0] tag;
    logic [63:0] data0;
    int          stall_beat;
    int          stall_len;
    int          bubble_after;
    int          bubble_len;
  } vec_t;

  bus_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every completed read beat is popped and compared
  always @(negedge clk) begin
    if (!reset && bus_respcyc && bus_respack) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_beat: got %h expected none", bus_resp);
      end else begin
        e = sb.pop_front();
        if (bus_resp !== e.d || bus_resptag !== e.t) begin
          errors++;
          $display("FAIL rd_beat: got %h/%h expected %h/%h",
                   bus_resp, bus_resptag, e.d, e.t);
        end
      end
    end
  end

  task automatic send_header(input logic [63:0] addr,
                             input logic [12:0] tag);
    int n;
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    n = 0;
    while (!bus_reqack && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!bus_reqack) begin
      errors++;
      $display("FAIL hdr_ack_timeout: got 0 expected 1");
    end
    tick();
  endtask

  task automatic do_write(input vec_t v);
    send_header(v.addr, v.tag);
    for (int i = 0; i < 8; i++) begin
      bus_reqcyc = 1'b1;
      bus_req    = v.data0 + 64'(i);
      tick();
      if (i == v.bubble_after) begin
        bus_reqcyc = 1'b0;
        bus_req    = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int b = 0; b < v.bubble_len; b++) begin
          check("wr_bubble_ack", 64'(bus_reqack), 64'd1);
          tick();
        end
      end
    end
    bus_reqcyc = 1'b0;
    check("wr_ack_drop", 64'(bus_reqack), 64'd0);
  endtask

  task automatic do_read(input vec_t v, input int reset_beat);
    int n;
    for (int i = 0; i < 8; i++) sb.push_back('{v.data0 + 64'(i), v.tag});
    send_header(v.addr, v.tag);
    bus_reqcyc = 1'b0;
    check("rd_wait_busy", 64'(busy), 64'd1);
    n = 0;
    while (!bus_respcyc && n < 50) begin
      tick();
      n++;
    end
    check("rd_latency", 64'(n), 64'd4);
    for (int i = 0; i < 8; i++) begin
      if (i == reset_beat) begin
        bus_respack = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_respcyc", 64'(bus_respcyc), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_resp", bus_resp, 64'd0);
        check("rst_mid_tag", 64'(bus_resptag), 64'd0);
        sb.delete();
        return;
      end
      if (i == v.stall_beat) begin
        bus_respack = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          tick();
          check("stall_respcyc", 64'(bus_respcyc), 64'd1);
          check("stall_resp", bus_resp, v.data0 + 64'(i));
        end
      end
      bus_respack = 1'b1;
      tick();
    end
    bus_respack = 1'b0;
    check("rd_end_respcyc", 64'(bus_respcyc), 64'd0);
    check("rd_sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t rv;

    vecs[0] = '{1, 64'h1000,  13'h1001, 64'hA0, -1, 0, -1, 0};
    vecs[1] = '{0, 64'h1008,  13'h0005, 64'hA0, -1, 0, -1, 0};
    vecs[2] = '{0, 64'h1008,  13'h0005, 64'hA0,  2, 3, -1, 0};
    vecs[3] = '{1, 64'h7FFC0, 13'h1002, 64'hFEED_0000_0000_00B0,
                -1, 0, -1, 0};
    vecs[4] = '{0, 64'h3FFC0, 13'h0007, 64'hFEED_0000_0000_00B0,
                -1, 0, -1, 0};
    vecs[5] = '{0, 64'h7FFC0, 13'h0ABC, 64'hFEED_0000_0000_00B0,
                 5, 1, -1, 0};
    vecs[6] = '{1, 64'h2000,  13'h1FFF, 64'hDEAD_BEEF_0000_00C0,
                -1, 0,  3, 2};
    vecs[7] = '{0, 64'h2030,  13'h0003, 64'hDEAD_BEEF_0000_00C0,
                -1, 0, -1, 0};
    vecs[8] = '{0, 64'h1000,  13'h0FFF, 64'hA0, -1, 0, -1, 0};

    reset       = 1'b1;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_reqack", 64'(bus_reqack), 64'd0);
    check("rst_respcyc", 64'(bus_respcyc), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp", bus_resp, 64'd0);
    check("rst_resptag", 64'(bus_resptag), 64'd0);

    for (int k = 0; k < 9; k++) begin
      if (vecs[k].wr) do_write(vecs[k]);
      else do_read(vecs[k], -1);
      tick();
    end

    rv = vecs[1];
    do_read(rv, 5);
    tick();
    do_read(rv, -1);
    tick();

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
